// File: rtl/mux_scan_sequencer_if.sv
// mux_scan_sequencer_if: control, mux-select and frame-report signals of the scan sequencer
interface mux_scan_sequencer_if;
  logic       start;
  logic       continuous;
  logic [3:0] enable_mask;
  logic       q;
  logic       select1;
  logic       select2;
  logic [3:0] sample;
  logic       valid;
  logic       busy;
  modport master (
    output start, continuous, enable_mask, q,
    input  select1, select2, sample, valid, busy
  );
  modport slave (
    input  start, continuous, enable_mask, q,
    output select1, select2, sample, valid, busy
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps a 4:1 mux through enabled channels, dwells, samples q and reports a 4-bit frame
module mux_scan_sequencer #(
  parameter int DWELL = 2,
  parameter int CNT_W = 4
) (
  input logic                  clk,
  input logic                  rst,
  mux_scan_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
  state_t             r_state;
  logic [1:0]         r_sel;
  logic [3:0]         r_mask;
  logic [3:0]         r_acc;
  logic [3:0]         r_sample;
  logic               r_valid;
  logic               r_busy;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         w_above;
  logic [3:0]         w_acc;
  logic               w_last;
  function automatic logic [1:0] lowest(input logic [3:0] m);
    return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
  endfunction
  // enabled channels strictly above the one currently on the selects
  assign w_above = r_mask & (4'b1110 << r_sel);
  assign w_acc   = r_acc | (4'(bus.q) << r_sel);
  assign w_last  = r_cnt == CNT_W'(DWELL - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sel    <= '0;
      r_mask   <= '0;
      r_acc    <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: if (bus.start && |bus.enable_mask) begin
          r_mask  <= bus.enable_mask;
          r_acc   <= '0;
          r_sel   <= lowest(bus.enable_mask);
          r_cnt   <= '0;
          r_busy  <= 1'b1;
          r_state <= SETTLE;
        end
        SETTLE: if (!w_last) r_cnt <= r_cnt + CNT_W'(1);
        else begin
          r_acc <= w_acc;
          r_cnt <= '0;
          if (|w_above) r_sel <= lowest(w_above);
          else begin
            r_sample <= w_acc;
            r_valid  <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= DONE;
          end
        end
        DONE: if (bus.continuous) begin
          r_acc   <= '0;
          r_sel   <= lowest(r_mask);
          r_cnt   <= '0;
          r_busy  <= 1'b1;
          r_state <= SETTLE;
        end else begin
          r_sel   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.select1 = r_sel[1];
  assign bus.select2 = r_sel[0];
  assign bus.sample  = r_sample;
  assign bus.valid   = r_valid;
  assign bus.busy    = r_busy;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: directed scans on DWELL=2 and DWELL=3 instances with a frame scoreboard
module tb_mux_scan_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mux_scan_sequencer_if b2();
  mux_scan_sequencer_if b3();
  logic [3:0] mux2 = '0;
  logic [3:0] mux3 = '0;
  assign b2.q = mux2[{b2.select1, b2.select2}];
  assign b3.q = mux3[{b3.select1, b3.select2}];
  mux_scan_sequencer #(.DWELL(2), .CNT_W(4)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
  mux_scan_sequencer #(.DWELL(3), .CNT_W(4)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));
  int tests = 0;
  int errors = 0;
  int nv2 = 0;
  int nv3 = 0;
  logic pv2 = 1'b0;
  logic pv3 = 1'b0;
  logic [3:0] exp2[$];
  logic [3:0] exp3[$];
  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (b2.valid) begin
      nv2++;
      if (exp2.size() > 0) chk("sample_d2", 8'(b2.sample), 8'(exp2.pop_front()));
      else begin
        tests++;
        errors++;
        $display("FAIL unexpected_valid_d2: sample %b with no frame expected", b2.sample);
      end
      if (pv2) begin
        tests++;
        errors++;
        $display("FAIL valid_twice_d2: valid high on consecutive cycles");
      end
    end
    pv2 = b2.valid;
  end
  always @(negedge clk) begin
    if (b3.valid) begin
      nv3++;
      if (exp3.size() > 0) chk("sample_d3", 8'(b3.sample), 8'(exp3.pop_front()));
      else begin
        tests++;
        errors++;
        $display("FAIL unexpected_valid_d3: sample %b with no frame expected", b3.sample);
      end
      if (pv3) begin
        tests++;
        errors++;
        $display("FAIL valid_twice_d3: valid high on consecutive cycles");
      end
    end
    pv3 = b3.valid;
  end
  task automatic start2(input logic [3:0] m, input logic c);
    b2.enable_mask = m;
    b2.continuous  = c;
    b2.start       = 1'b1;
    @(negedge clk);
    b2.start = 1'b0;
  endtask
  task automatic start3(input logic [3:0] m);
    b3.enable_mask = m;
    b3.continuous  = 1'b0;
    b3.start       = 1'b1;
    @(negedge clk);
    b3.start = 1'b0;
  endtask
  task automatic wait_valid2(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!b2.valid && c < 20);
  endtask
  initial begin
    int c;
    int base;
    int per[3] = '{4, 5, 4};
    b2.start = 1'b0; b2.continuous = 1'b0; b2.enable_mask = '0;
    b3.start = 1'b0; b3.continuous = 1'b0; b3.enable_mask = '0;
    repeat (2) @(negedge clk);
    chk("rst_d2", 8'({b2.sample, b2.valid, b2.busy, b2.select1, b2.select2}), 8'h00);
    chk("rst_d3", 8'({b3.sample, b3.valid, b3.busy, b3.select1, b3.select2}), 8'h00);
    rst = 1'b0;
    @(negedge clk);
    start2(4'b0000, 1'b0);
    repeat (3) begin
      chk("mask0_idle", 8'({b2.busy, b2.select1, b2.select2}), 8'h00);
      @(negedge clk);
    end
    mux2 = 4'b0101;
    exp2.push_back(4'b0101);
    start2(4'b1111, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("full_step%0d", i), 8'({b2.busy, b2.valid, b2.select1, b2.select2}), 8'({2'b10, 2'(i / 2)}));
      @(negedge clk);
    end
    chk("full_valid", 8'({b2.valid, b2.busy}), 8'b10);
    @(negedge clk);
    chk("full_back_idle", 8'({b2.valid, b2.busy, b2.select1, b2.select2}), 8'h00);
    mux3 = 4'b1111;
    exp3.push_back(4'b1010);
    start3(4'b1010);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("sparse_step%0d", i), 8'({b3.busy, b3.valid, b3.select1, b3.select2}), 8'({2'b10, (i < 3) ? 2'd1 : 2'd3}));
      @(negedge clk);
    end
    chk("sparse_valid", 8'({b3.valid, b3.busy}), 8'b10);
    mux2 = 4'b0001;
    exp2.push_back(4'b0001);
    exp2.push_back(4'b0011);
    exp2.push_back(4'b0001);
    base = nv2;
    start2(4'b0011, 1'b1);
    for (int f = 0; f < 3; f++) begin
      wait_valid2(c);
      chk($sformatf("cont_period%0d", f), 8'(c), 8'(per[f]));
      mux2[1] = ~mux2[1];
      if (f == 1) begin
        @(negedge clk);
        b2.continuous = 1'b0;
      end
    end
    @(negedge clk);
    chk("cont_stop_idle", 8'({b2.busy, b2.select1, b2.select2}), 8'h00);
    repeat (10) @(negedge clk);
    chk("cont_frames", 8'(nv2 - base), 8'd3);
    mux2 = 4'b1111;
    start2(4'b1111, 1'b0);
    repeat (4) @(negedge clk);
    chk("midrst_pre_sel", 8'({b2.select1, b2.select2}), 8'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_state", 8'({b2.sample, b2.valid, b2.busy, b2.select1, b2.select2}), 8'h00);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    mux2 = 4'b1010;
    exp2.push_back(4'b1010);
    start2(4'b1111, 1'b0);
    wait_valid2(c);
    chk("after_rst_latency", 8'(c), 8'd8);
    repeat (2) @(negedge clk);
    mux2 = 4'b1111;
    exp2.push_back(4'b0110);
    base = nv2;
    start2(4'b0110, 1'b0);
    b2.enable_mask = 4'b1111;
    b2.start = 1'b1;
    @(negedge clk);
    b2.start = 1'b0;
    repeat (15) @(negedge clk);
    chk("busy_start_ignored", 8'(nv2 - base), 8'd1);
    chk("busy_start_idle", 8'({b2.busy, b2.select1, b2.select2}), 8'h00);
    chk("queue_d2_empty", 8'(exp2.size()), 8'd0);
    chk("queue_d3_empty", 8'(exp3.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream controller for the 4:1 channel mux.
- Drives the mux selects (select1, select2) through each enabled channel in turn and holds each select for a fixed dwell time so the mux output settles.
- Samples the mux output q at the end of each dwell and assembles a 4-bit frame, then reports it with a one-cycle valid pulse.
- Supports single-shot scans (start pulse) and free-running continuous scans.

Parameters:
- DWELL, 2, cycles each select code is held before q is sampled; legal range 1..15.
- CNT_W, 4, width of the internal dwell counter; must satisfy 2^CNT_W > DWELL.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  scan request; sampled only in IDLE.
- continuous  in  1  1 = restart automatically after each frame; sampled at every frame end.
- enable_mask  in  4  bit i = 1 includes channel i in the scan; latched when start is accepted.
- q  in  1  mux output (driven by the mux fed from select1/select2).
- select1  out  1  mux select MSB; registered.
- select2  out  1  mux select LSB; registered.
- sample  out  4  last completed frame; bit i = value of q on channel i, 0 for disabled channels.
- valid  out  1  one-cycle pulse when sample is updated.
- busy  out  1  high while a scan is in progress (SETTLE state).

Behaviour:
- Channel encoding: {select1,select2} = channel index; 00=A(ch0), 01=B(ch1), 10=C(ch2), 11=D(ch3).
- Reset (rst=1 at a clock edge, including mid-scan):
  - state <= IDLE; select1/select2 <= 0; sample <= 0; valid <= 0; busy <= 0.
  - Latched mask and dwell counter <= 0.
  - Any scan in progress is abandoned; no valid pulse is produced.
- IDLE: busy=0, valid=0, selects=00.
  - start=1 and enable_mask != 0: latch mask, clear the frame accumulator, load the selects with the lowest enabled channel, counter <= 0, go to SETTLE.
  - start=1 and enable_mask == 0: ignored; stay in IDLE.
- SETTLE: busy=1, selects constant. The counter increments each cycle.
  - At the edge where the counter == DWELL-1: accumulator[ch] <= q.
  - If a higher-indexed enabled channel exists: selects <= next enabled channel, counter <= 0, stay in SETTLE.
  - Otherwise: go to DONE.
  - Each enabled channel is therefore held for exactly DWELL cycles, and q is sampled in the last of them.
- DONE (one cycle): sample <= accumulator, registered together with valid=1. busy=0.
  - continuous=1: re-latch the stored mask (not the enable_mask input), clear the accumulator, and go to SETTLE on the lowest enabled channel. Back-to-back frames have exactly one DONE cycle between them.
  - continuous=0: go to IDLE; selects <= 00.
- Latency: valid is high during the cycle following the (K·DWELL)-th edge after the edge that accepted start, where K = popcount(mask). Single-shot scan period = K·DWELL+1 cycles; continuous frame period = K·DWELL+1.
- Input sampling rules:
  - start while busy or in DONE: ignored; no queuing.
  - enable_mask changes mid-scan: no effect until the next accepted start.
  - continuous dropping to 0 mid-scan: the current frame completes, then the block returns to IDLE.
- Held values:
  - sample holds its value between frames.
  - valid is never high for two consecutive cycles.
  - Disabled channels never appear on the selects and read 0 in sample.
- DWELL=1: the select changes every cycle, and q is sampled in the same cycle the select is presented.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> selects=00, sample=0000, valid=0, busy=0; start=1 with mask=0000 -> stays in IDLE, busy never rises.
- Full scan, DWELL=2, mask=1111, mux inputs A=1 B=0 C=1 D=0 -> selects step 00,01,10,11, two cycles each; valid pulses once, 8 edges after start; sample=0101 (bit0=A); busy high for 8 cycles.
- Sparse mask 1010, DWELL=3, A=B=C=D=1 -> only codes 01 and 11 appear, 3 cycles each; valid after 6 edges; sample=1010.
- Continuous mode, mask=0011, DWELL=2; toggle B between frames -> valid every 5 cycles, sample alternating 0001/0011; set continuous=0 -> exactly one more valid, then IDLE with selects=00.
- Reset mid-scan: assert rst while the selects are at 10 -> next cycle selects=00, busy=0, sample=0000, no valid pulse; a new start scans normally.
- Start ignored while busy: pulse start again mid-scan with a different mask -> the frame is unchanged, exactly one valid, and no second scan follows.
